cpu_dmem_subsystem: RTL and testbench

Single-cycle RV32I processor core bundled with its data memory and a data-bus address decoder. Instructions are fetched from an external instruction ROM over iaddr/idata. Data accesses go to internal dmem or are routed to one external memory-mapped peripheral port. The block sits between the instruction ROM and the peripheral layer of the SoC; x31 and PC are exported for debug and observation.

---
 rtl/cpu_dmem_subsystem_pkg.sv | 70 +++++++
 rtl/cpu_dmem_subsystem_regfile.sv | 33 +++
 rtl/cpu_dmem_subsystem.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_dmem_subsystem.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dmem_subsystem_pkg.sv
// Shared constants and types for the single-cycle RV32I core
// and its data-memory subsystem.
package cpu_dmem_subsystem_pkg;

  localparam int Instr_width = 32;
  localparam int data_width  = 32;
  localparam int WE_width    = 4;
  localparam int PER_BIT     = 12;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic logic [data_width-1:0] alu(
    input alu_op_e op,
    input logic [data_width-1:0] a,
    input logic [data_width-1:0] b
  );
    logic [data_width-1:0] y;
    y = a + b;
    unique case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cpu_dmem_subsystem_regfile.sv
// 32x32 register file: two async read ports, one sync write
// port, x0 hardwired to zero, synchronous clear on reset.
module regfile
  import cpu_dmem_subsystem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  input  logic [4:0]            wa,
  input  logic                  we,
  input  logic [data_width-1:0] wd,
  output logic [data_width-1:0] rd1,
  output logic [data_width-1:0] rd2,
  output logic [data_width-1:0] x31
);

  logic [data_width-1:0] rf [32];

  assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
  assign x31 = rf[31];

  // clear on reset, otherwise write rd unless it is x0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && wa != 5'd0) begin
      rf[wa] <= wd;
    end
  end

endmodule

// File: rtl/cpu_dmem_subsystem.sv
// Single-cycle RV32I core with local dmem and an addr[12]
// decoder that routes data accesses to dmem or a peripheral.
module cpu_dmem_subsystem
  import cpu_dmem_subsystem_pkg::*;
#(
  parameter int DMEM_WORDS = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [Instr_width-1:0] iaddr,
  input  logic [Instr_width-1:0] idata,
  output logic [data_width-1:0]  addr_per,
  output logic [data_width-1:0]  wdata_per,
  output logic [WE_width-1:0]    we_per,
  output logic                   ce_per,
  input  logic [data_width-1:0]  rdata_per,
  output logic [data_width-1:0]  x31,
  output logic [Instr_width-1:0] PC
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, npc;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        f7b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, alu_b, alu_y, wb, ld;
  logic        rf_we, take;
  alu_op_e     aop;
  logic [31:0] daddr, wdata, rdata_cpu, mem_rdata;
  logic [3:0]  we_cpu, we_mem;
  logic [1:0]  ce;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign opc  = idata[6:0];
  assign rd   = idata[11:7];
  assign f3   = idata[14:12];
  assign rs1  = idata[19:15];
  assign rs2  = idata[24:20];
  assign f7b5 = idata[30];

  assign imm_i = {{20{idata[31]}}, idata[31:20]};
  assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
  assign imm_b = {{19{idata[31]}}, idata[31], idata[7],
                  idata[30:25], idata[11:8], 1'b0};
  assign imm_u = {idata[31:12], 12'd0};
  assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12],
                  idata[20], idata[30:21], 1'b0};

  assign iaddr = pc_q;
  assign PC    = pc_q;

  regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1),
    .ra2   (rs2),
    .wa    (rd),
    .we    (rf_we),
    .wd    (wb),
    .rd1   (rs1v),
    .rd2   (rs2v),
    .x31   (x31)
  );

  assign daddr = rs1v + ((opc == STORE) ? imm_s : imm_i);
  assign alu_b = (opc == OP) ? rs2v : imm_i;
  assign alu_y = alu(aop, rs1v, alu_b);

  assign wdata = (f3 == F3_B) ? {4{rs2v[7:0]}}  :
                 (f3 == F3_H) ? {2{rs2v[15:0]}} : rs2v;

  // ALU operation from funct3; SUB only for register-register
  always_comb begin
    aop = ALU_ADD;
    unique case (f3)
      F3_ADD:  aop = (opc == OP && f7b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  aop = ALU_SLL;
      F3_SLT:  aop = ALU_SLT;
      F3_SLTU: aop = ALU_SLTU;
      F3_XOR:  aop = ALU_XOR;
      F3_SR:   aop = f7b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   aop = ALU_OR;
      F3_AND:  aop = ALU_AND;
      default: aop = ALU_ADD;
    endcase
  end

  // branch condition
  always_comb begin
    take = 1'b0;
    case (f3)
      F3_BEQ:  take = rs1v == rs2v;
      F3_BNE:  take = rs1v != rs2v;
      F3_BLT:  take = $signed(rs1v) < $signed(rs2v);
      F3_BGE:  take = $signed(rs1v) >= $signed(rs2v);
      F3_BLTU: take = rs1v < rs2v;
      F3_BGEU: take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
  end

  // load lane select and extension
  always_comb begin
    lb = rdata_cpu[8*daddr[1:0] +: 8];
    lh = daddr[1] ? rdata_cpu[31:16] : rdata_cpu[15:0];
    case (f3)
      F3_B:    ld = {{24{lb[7]}}, lb};
      F3_H:    ld = {{16{lh[15]}}, lh};
      F3_BU:   ld = {24'd0, lb};
      F3_HU:   ld = {16'd0, lh};
      default: ld = rdata_cpu;
    endcase
  end

  // main decode: next PC, writeback and store enables
  always_comb begin
    npc    = pc_q + 32'd4;
    wb     = '0;
    rf_we  = 1'b0;
    we_cpu = '0;
    unique case (1'b1)
      opc == LUI: begin
        wb    = imm_u;
        rf_we = 1'b1;
      end
      opc == AUIPC: begin
        wb    = pc_q + imm_u;
        rf_we = 1'b1;
      end
      opc == JAL: begin
        wb    = pc_q + 32'd4;
        rf_we = 1'b1;
        npc   = pc_q + imm_j;
      end
      opc == JALR: begin
        wb    = pc_q + 32'd4;
        rf_we = 1'b1;
        npc   = (rs1v + imm_i) & ~32'd1;
      end
      opc == BRANCH: begin
        if (take) npc = pc_q + imm_b;
      end
      opc == LOAD: begin
        wb    = ld;
        rf_we = 1'b1;
      end
      opc == STORE: begin
        case (f3)
          F3_B:    we_cpu = 4'b0001 << daddr[1:0];
          F3_H:    we_cpu = 4'b0011 << {daddr[1], 1'b0};
          F3_W:    we_cpu = 4'b1111;
          default: we_cpu = 4'b0000;
        endcase
      end
      opc == OPIMM, opc == OP: begin
        wb    = alu_y;
        rf_we = 1'b1;
      end
      default: begin
        npc = pc_q + 32'd4;
      end
    endcase
    if (reset) we_cpu = '0;
  end

  // program counter
  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= npc;
  end

  // data-bus arbiter: select on addr[12], gate enables
  always_comb begin
    ce        = daddr[PER_BIT] ? 2'b10 : 2'b01;
    we_per    = ce[1] ? we_cpu : '0;
    we_mem    = ce[0] ? we_cpu : '0;
    rdata_cpu = ce[0] ? mem_rdata : rdata_per;
  end

  assign ce_per    = ce[1];
  assign addr_per  = daddr;
  assign wdata_per = wdata;

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] widx;

  assign widx      = daddr[AW+1:2];
  assign mem_rdata = mem[widx];

  // dmem byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_mem[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_cpu_dmem_subsystem.sv
// Directed testbench for cpu_dmem_subsystem with a small
// instruction ROM model and a fixed peripheral read value.
module tb_cpu_dmem_subsystem;

  logic        clk;
  logic        reset;
  logic [31:0] iaddr, idata;
  logic [31:0] addr_per, wdata_per, rdata_per;
  logic [3:0]  we_per;
  logic        ce_per;
  logic [31:0] x31, pc;

  logic [31:0] rom [0:63];
  int n_cmp = 0;
  int n_err = 0;

  assign idata = rom[iaddr[7:2]];

  cpu_dmem_subsystem dut (
    .clk       (clk),
    .reset     (reset),
    .iaddr     (iaddr),
    .idata     (idata),
    .addr_per  (addr_per),
    .wdata_per (wdata_per),
    .we_per    (we_per),
    .ce_per    (ce_per),
    .rdata_per (rdata_per),
    .x31       (x31),
    .PC        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] i_t(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1],
            imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = i_t(12'd5, 5'd0, 3'd0, 5'd31, 7'h13);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (pc !== 32'd0) begin
      n_err++;
      $display("FAIL reset_pc: got %h want %h", pc, 32'd0);
    end
    n_cmp++;
    if (x31 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_x31: got %h want %h", x31, 32'd0);
    end
    n_cmp++;
    if (we_per !== 4'd0) begin
      n_err++;
      $display("FAIL reset_we: got %h want %h", we_per, 4'd0);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (x31 !== 32'd5) begin
      n_err++;
      $display("FAIL first_addi_x31: got %h want %h", x31, 32'd5);
    end
    n_cmp++;
    if (pc !== 32'd4) begin
      n_err++;
      $display("FAIL first_addi_pc: got %h want %h", pc, 32'd4);
    end
  endtask

  task automatic test_word_store_load();
    clear_rom();
    rom[0] = u_t(20'h12345, 5'd1, 7'h37);
    rom[1] = i_t(12'h678, 5'd1, 3'd0, 5'd1, 7'h13);
    rom[2] = s_t(12'd0, 5'd1, 5'd0, 3'd2);
    rom[3] = i_t(12'd0, 5'd0, 3'd2, 5'd31, 7'h03);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (we_per !== 4'd0) begin
        n_err++;
        $display("FAIL sw_dmem_we_per[%0d]: got %h want %h",
                 i, we_per, 4'd0);
      end
      if (i == 2) begin
        n_cmp++;
        if (ce_per !== 1'b0) begin
          n_err++;
          $display("FAIL sw_dmem_ce_per: got %b want %b",
                   ce_per, 1'b0);
        end
      end
      step();
    end
    n_cmp++;
    if (x31 !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL lw_after_sw: got %h want %h",
               x31, 32'h1234_5678);
    end
  endtask

  task automatic test_byte_half();
    clear_rom();
    rom[0] = i_t(12'h0AB, 5'd0, 3'd0, 5'd2, 7'h13);
    rom[1] = s_t(12'd1, 5'd2, 5'd0, 3'd0);
    rom[2] = i_t(12'd1, 5'd0, 3'd4, 5'd31, 7'h03);
    rom[3] = i_t(12'd1, 5'd0, 3'd0, 5'd30, 7'h03);
    rom[4] = i_t(12'd2, 5'd0, 3'd1, 5'd31, 7'h03);
    rom[5] = i_t(12'd0, 5'd0, 3'd1, 5'd31, 7'h03);
    do_reset();
    repeat (3) step();
    n_cmp++;
    if (x31 !== 32'h0000_00AB) begin
      n_err++;
      $display("FAIL lbu: got %h want %h", x31, 32'h0000_00AB);
    end
    step();
    n_cmp++;
    if (dut.u_rf.rf[30] !== 32'hFFFF_FFAB) begin
      n_err++;
      $display("FAIL lb_sext: got %h want %h",
               dut.u_rf.rf[30], 32'hFFFF_FFAB);
    end
    n_cmp++;
    if (dut.mem[0] !== 32'h1234_AB78) begin
      n_err++;
      $display("FAIL sb_word: got %h want %h",
               dut.mem[0], 32'h1234_AB78);
    end
    step();
    n_cmp++;
    if (x31 !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL lh_upper: got %h want %h", x31, 32'h0000_1234);
    end
    step();
    n_cmp++;
    if (x31 !== 32'hFFFF_AB78) begin
      n_err++;
      $display("FAIL lh_sext: got %h want %h", x31, 32'hFFFF_AB78);
    end
  endtask

  task automatic test_periph();
    clear_rom();
    rdata_per = 32'hCAFE_F00D;
    rom[0] = u_t(20'h12345, 5'd1, 7'h37);
    rom[1] = i_t(12'h678, 5'd1, 3'd0, 5'd1, 7'h13);
    rom[2] = u_t(20'h00001, 5'd3, 7'h37);
    rom[3] = s_t(12'd0, 5'd1, 5'd3, 3'd2);
    rom[4] = i_t(12'd0, 5'd3, 3'd2, 5'd31, 7'h03);
    rom[5] = s_t(12'd3, 5'd1, 5'd3, 3'd0);
    do_reset();
    repeat (3) step();
    n_cmp++;
    if (ce_per !== 1'b1) begin
      n_err++;
      $display("FAIL per_sw_ce: got %b want %b", ce_per, 1'b1);
    end
    n_cmp++;
    if (we_per !== 4'b1111) begin
      n_err++;
      $display("FAIL per_sw_we: got %b want %b", we_per, 4'b1111);
    end
    n_cmp++;
    if (addr_per !== 32'h0000_1000) begin
      n_err++;
      $display("FAIL per_sw_addr: got %h want %h",
               addr_per, 32'h0000_1000);
    end
    n_cmp++;
    if (wdata_per !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL per_sw_wdata: got %h want %h",
               wdata_per, 32'h1234_5678);
    end
    step();
    n_cmp++;
    if (dut.mem[0] !== 32'h1234_AB78) begin
      n_err++;
      $display("FAIL per_sw_dmem_kept: got %h want %h",
               dut.mem[0], 32'h1234_AB78);
    end
    n_cmp++;
    if (we_per !== 4'b0000) begin
      n_err++;
      $display("FAIL per_lw_we: got %b want %b", we_per, 4'b0000);
    end
    step();
    n_cmp++;
    if (x31 !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL per_lw: got %h want %h", x31, 32'hCAFE_F00D);
    end
    n_cmp++;
    if (we_per !== 4'b1000) begin
      n_err++;
      $display("FAIL per_sb_we: got %b want %b", we_per, 4'b1000);
    end
    n_cmp++;
    if (wdata_per !== 32'h7878_7878) begin
      n_err++;
      $display("FAIL per_sb_wdata: got %h want %h",
               wdata_per, 32'h7878_7878);
    end
  endtask

  task automatic test_branch_jump();
    clear_rom();
    rom[0]  = i_t(12'd1, 5'd0, 3'd0, 5'd1, 7'h13);
    rom[1]  = b_t(13'd8, 5'd0, 5'd1, 3'd0);
    rom[2]  = b_t(13'd8, 5'd1, 5'd1, 3'd0);
    rom[3]  = i_t(12'd99, 5'd0, 3'd0, 5'd31, 7'h13);
    rom[4]  = b_t(13'd16, 5'd0, 5'd1, 3'd1);
    rom[8]  = j_t(21'd8, 5'd31);
    rom[10] = i_t(12'h041, 5'd0, 3'd0, 5'd5, 7'h13);
    rom[11] = i_t(12'd0, 5'd5, 3'd0, 5'd31, 7'h67);
    rom[16] = i_t(12'd1, 5'd31, 3'd0, 5'd31, 7'h13);
    do_reset();
    step();
    step();
    n_cmp++;
    if (pc !== 32'h08) begin
      n_err++;
      $display("FAIL beq_not_taken: got %h want %h", pc, 32'h08);
    end
    step();
    n_cmp++;
    if (pc !== 32'h10) begin
      n_err++;
      $display("FAIL beq_taken: got %h want %h", pc, 32'h10);
    end
    step();
    n_cmp++;
    if (pc !== 32'h20) begin
      n_err++;
      $display("FAIL bne_taken: got %h want %h", pc, 32'h20);
    end
    step();
    n_cmp++;
    if (pc !== 32'h28) begin
      n_err++;
      $display("FAIL jal_pc: got %h want %h", pc, 32'h28);
    end
    n_cmp++;
    if (x31 !== 32'h24) begin
      n_err++;
      $display("FAIL jal_link: got %h want %h", x31, 32'h24);
    end
    step();
    step();
    n_cmp++;
    if (pc !== 32'h40) begin
      n_err++;
      $display("FAIL jalr_odd: got %h want %h", pc, 32'h40);
    end
    n_cmp++;
    if (x31 !== 32'h30) begin
      n_err++;
      $display("FAIL jalr_link: got %h want %h", x31, 32'h30);
    end
    step();
    n_cmp++;
    if (x31 !== 32'h31) begin
      n_err++;
      $display("FAIL after_jalr: got %h want %h", x31, 32'h31);
    end
  endtask

  task automatic test_alu();
    clear_rom();
    rom[0]  = i_t(12'hFF0, 5'd0, 3'd0, 5'd1, 7'h13);
    rom[1]  = i_t(12'h402, 5'd1, 3'd5, 5'd2, 7'h13);
    rom[2]  = i_t(12'h01C, 5'd1, 3'd5, 5'd3, 7'h13);
    rom[3]  = r_t(7'h20, 5'd1, 5'd3, 3'd0, 5'd31);
    rom[4]  = r_t(7'h00, 5'd3, 5'd1, 3'd2, 5'd31);
    rom[5]  = r_t(7'h00, 5'd3, 5'd1, 3'd3, 5'd31);
    rom[6]  = i_t(12'hFFF, 5'd1, 3'd4, 5'd31, 7'h13);
    rom[7]  = i_t(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
    rom[8]  = r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd31);
    rom[9]  = b_t(13'd8, 5'd3, 5'd1, 3'd4);
    rom[11] = r_t(7'h00, 5'd2, 5'd3, 3'd1, 5'd31);
    rom[12] = 32'hFFFF_FFFF;
    do_reset();
    step();
    step();
    n_cmp++;
    if (dut.u_rf.rf[2] !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL srai: got %h want %h",
               dut.u_rf.rf[2], 32'hFFFF_FFFC);
    end
    step();
    n_cmp++;
    if (dut.u_rf.rf[3] !== 32'h0000_000F) begin
      n_err++;
      $display("FAIL srli: got %h want %h",
               dut.u_rf.rf[3], 32'h0000_000F);
    end
    step();
    n_cmp++;
    if (x31 !== 32'h1F) begin
      n_err++;
      $display("FAIL sub: got %h want %h", x31, 32'h1F);
    end
    step();
    n_cmp++;
    if (x31 !== 32'h1) begin
      n_err++;
      $display("FAIL slt: got %h want %h", x31, 32'h1);
    end
    step();
    n_cmp++;
    if (x31 !== 32'h0) begin
      n_err++;
      $display("FAIL sltu: got %h want %h", x31, 32'h0);
    end
    step();
    n_cmp++;
    if (x31 !== 32'hF) begin
      n_err++;
      $display("FAIL xori: got %h want %h", x31, 32'hF);
    end
    step();
    step();
    n_cmp++;
    if (x31 !== 32'h0) begin
      n_err++;
      $display("FAIL x0_write: got %h want %h", x31, 32'h0);
    end
    step();
    n_cmp++;
    if (pc !== 32'h2C) begin
      n_err++;
      $display("FAIL blt_neg: got %h want %h", pc, 32'h2C);
    end
    step();
    n_cmp++;
    if (x31 !== 32'hF000_0000) begin
      n_err++;
      $display("FAIL sll_low5: got %h want %h", x31, 32'hF000_0000);
    end
    step();
    n_cmp++;
    if (x31 !== 32'hF000_0000) begin
      n_err++;
      $display("FAIL bad_op_x31: got %h want %h",
               x31, 32'hF000_0000);
    end
    n_cmp++;
    if (pc !== 32'h34) begin
      n_err++;
      $display("FAIL bad_op_pc: got %h want %h", pc, 32'h34);
    end
  endtask

  task automatic test_mid_reset();
    clear_rom();
    rom[0] = i_t(12'd1, 5'd31, 3'd0, 5'd31, 7'h13);
    rom[1] = j_t(21'h1FFFFC, 5'd0);
    do_reset();
    repeat (5) step();
    n_cmp++;
    if (x31 !== 32'd3 || pc !== 32'd4) begin
      n_err++;
      $display("FAIL loop_state: got x31=%h pc=%h want x31=3 pc=4",
               x31, pc);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (pc !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset_pc: got %h want %h", pc, 32'd0);
    end
    n_cmp++;
    if (x31 !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset_x31: got %h want %h", x31, 32'd0);
    end
    n_cmp++;
    if (dut.mem[0] !== 32'h1234_AB78) begin
      n_err++;
      $display("FAIL mid_reset_dmem: got %h want %h",
               dut.mem[0], 32'h1234_AB78);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (x31 !== 32'd1) begin
      n_err++;
      $display("FAIL restart: got %h want %h", x31, 32'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rdata_per = 32'd0;
    clear_rom();
    test_reset();
    test_word_store_load();
    test_byte_half();
    test_periph();
    test_branch_jump();
    test_alu();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
